// File: rtl/mil_bc_seq.sv
// MIL-STD-1553 bus-controller message sequencer: sends command and data words through MIL_TXD,
// then collects the RT status word and any RT data words from MIL_RXD into the data buffer.
module mil_bc_seq #(
   parameter int RESP_TO = 2000,
   parameter int WORD_TO = 1100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  rt_addr,
   input  logic        tr,
   input  logic [4:0]  sub_addr,
   input  logic [4:0]  wcnt,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   output logic [15:0] stat_wd,
   output logic [4:0]  buf_ra,
   input  logic [15:0] buf_rd,
   output logic        buf_we,
   output logic [4:0]  buf_wa,
   output logic [15:0] buf_wd,
   output logic        txen,
   output logic [15:0] dat,
   output logic        tx_cw,
   input  logic        tx_busy,
   input  logic        ok_rx,
   input  logic [15:0] sr_dat,
   input  logic        CW_DW
);

   localparam int TMAX = (RESP_TO > WORD_TO) ? RESP_TO : WORD_TO;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [3:0] {
      IDLE,
      CW_TX,
      CW_WAIT,
      DW_FETCH,
      DW_TX,
      DW_WAIT,
      SW_WAIT,
      RX_DW,
      FIN
   } state_t;

   state_t        state;
   logic [4:0]    rt_q;
   logic [4:0]    sub_q;
   logic [4:0]    wcnt_q;
   logic          tr_q;
   logic [5:0]    n_q;
   logic [5:0]    idx;
   logic [TW-1:0] timer;
   logic          seen_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= '0;
         stat_wd   <= '0;
         buf_ra    <= '0;
         buf_we    <= 1'b0;
         buf_wa    <= '0;
         buf_wd    <= '0;
         txen      <= 1'b0;
         dat       <= '0;
         tx_cw     <= 1'b0;
         rt_q      <= '0;
         sub_q     <= '0;
         wcnt_q    <= '0;
         tr_q      <= 1'b0;
         n_q       <= '0;
         idx       <= '0;
         timer     <= '0;
         seen_busy <= 1'b0;
      end else begin
         txen   <= 1'b0;
         buf_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rt_q   <= rt_addr;
                  tr_q   <= tr;
                  sub_q  <= sub_addr;
                  wcnt_q <= wcnt;
                  n_q    <= (wcnt == 5'd0) ? 6'd32 : {1'b0, wcnt};
                  idx    <= '0;
                  busy   <= 1'b1;
                  err    <= '0;
                  state  <= CW_TX;
               end
            end
            CW_TX: begin
               dat       <= {rt_q, tr_q, sub_q, wcnt_q};
               tx_cw     <= 1'b1;
               txen      <= 1'b1;
               seen_busy <= 1'b0;
               state     <= CW_WAIT;
            end
            // a word is finished only after tx_busy has been seen high and then low
            CW_WAIT, DW_WAIT: begin
               if (tx_busy) begin
                  seen_busy <= 1'b1;
               end else if (seen_busy) begin
                  if (!tr_q && (idx < n_q)) begin
                     buf_ra <= idx[4:0];
                     state  <= DW_FETCH;
                  end else begin
                     timer <= TW'(RESP_TO);
                     state <= SW_WAIT;
                  end
               end
            end
            DW_FETCH: begin
               state <= DW_TX;
            end
            DW_TX: begin
               dat       <= buf_rd;
               tx_cw     <= 1'b0;
               txen      <= 1'b1;
               idx       <= idx + 6'd1;
               seen_busy <= 1'b0;
               state     <= DW_WAIT;
            end
            // ok_rx is tested before the timer so a word arriving on the expiry cycle is accepted
            SW_WAIT: begin
               if (ok_rx) begin
                  if (!CW_DW) begin
                     err   <= 2'd3;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= FIN;
                  end else begin
                     stat_wd <= sr_dat;
                     if (sr_dat[15:11] != rt_q) begin
                        err   <= 2'd2;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                     end else if (tr_q) begin
                        timer <= TW'(WORD_TO);
                        state <= RX_DW;
                     end else begin
                        err   <= 2'd0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                     end
                  end
               end else if (timer == '0) begin
                  err   <= 2'd1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            RX_DW: begin
               if (ok_rx) begin
                  if (CW_DW) begin
                     err   <= 2'd3;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= FIN;
                  end else begin
                     buf_we <= 1'b1;
                     buf_wa <= idx[4:0];
                     buf_wd <= sr_dat;
                     idx    <= idx + 6'd1;
                     timer  <= TW'(WORD_TO);
                     if (idx + 6'd1 == n_q) begin
                        err   <= 2'd0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                     end
                  end
               end else if (timer == '0) begin
                  err   <= 2'd1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mil_bc_seq.sv
// Bench for mil_bc_seq: loopback transmitter, registered data buffer and a scripted remote terminal;
// expected words, writes, error codes and latencies come from each message's request and RT script.
module tb_mil_bc_seq;
   localparam int RESP_TO = 2000;
   localparam int WORD_TO = 1100;

   logic        clk = 1'b0;
   logic        rst, start, tr, busy, done, buf_we, txen, tx_cw, tx_busy, ok_rx, cw_dw;
   logic [4:0]  rt_addr, sub_addr, wcnt, buf_ra, buf_wa;
   logic [1:0]  err;
   logic [15:0] stat_wd, buf_rd, buf_wd, dat, sr_dat;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic [15:0] mem [32];
   logic [16:0] tx_q [$];
   int unsigned tx_cyc_q [$];
   int unsigned fall_q [$];
   logic [20:0] wr_q [$];
   int unsigned tx_done_cnt = 0;
   int unsigned done_cnt = 0;
   int unsigned done_cyc = 0;
   int unsigned last_ok_cyc = 0;
   logic [1:0]  err_at_done = '0;
   logic        busy_at_done = 1'b0;
   logic [15:0] exp_stat = '0;

   mil_bc_seq #(.RESP_TO(RESP_TO), .WORD_TO(WORD_TO)) dut (
      .clk(clk), .rst(rst), .start(start), .rt_addr(rt_addr), .tr(tr), .sub_addr(sub_addr),
      .wcnt(wcnt), .busy(busy), .done(done), .err(err), .stat_wd(stat_wd), .buf_ra(buf_ra),
      .buf_rd(buf_rd), .buf_we(buf_we), .buf_wa(buf_wa), .buf_wd(buf_wd), .txen(txen),
      .dat(dat), .tx_cw(tx_cw), .tx_busy(tx_busy), .ok_rx(ok_rx), .sr_dat(sr_dat), .CW_DW(cw_dw)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) buf_rd <= mem[buf_ra];

   always @(negedge clk) begin
      if (buf_we) wr_q.push_back({buf_wa, buf_wd});
      if (done) begin
         done_cnt     = done_cnt + 1;
         done_cyc     = cyc;
         err_at_done  = err;
         busy_at_done = busy;
      end
   end

   // transmitter: busy starts two clocks after txen and lasts twelve clocks
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (txen) begin
            tx_q.push_back({tx_cw, dat});
            tx_cyc_q.push_back(cyc);
            repeat (2) @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (12) @(posedge clk);
            #1 tx_busy = 1'b0;
            fall_q.push_back(cyc);
            tx_done_cnt = tx_done_cnt + 1;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_word(input logic [15:0] d, input logic c);
      ok_rx = 1'b1;
      sr_dat = d;
      cw_dw = c;
      last_ok_cyc = cyc;
      tick();
      ok_rx = 1'b0;
   endtask

   // kind: 0 normal, 1 no response, 2 status address mismatch, 3 status with data sync,
   //       4 RT data stops after k_in words, 5 command sync after k_in data words
   task automatic run_msg(input logic [4:0] a, input logic t, input logic [4:0] s,
                          input logic [4:0] w, input int kind, input logic [15:0] sw,
                          input bit seq_data, input int unsigned k_in);
      int unsigned n, ntx, k, txd0, done0, nwr;
      logic [15:0] cw;
      logic [15:0] rxd [32];
      logic [16:0] e;
      logic [1:0]  exp_err;
      n = (w == 5'd0) ? 32 : int'(w);
      cw = {a, t, s, w};
      ntx = t ? 1 : n + 1;
      tx_q.delete(); tx_cyc_q.delete(); fall_q.delete(); wr_q.delete();
      txd0 = tx_done_cnt;
      done0 = done_cnt;
      rt_addr = a; tr = t; sub_addr = s; wcnt = w; start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_rise", 32'(busy), 1);
      tick();
      check("cw_txen", 32'(txen), 1);
      check("cw_dat", 32'(dat), 32'(cw));
      check("cw_sync", 32'(tx_cw), 1);
      for (int i = 0; i < 2000 && tx_done_cnt < txd0 + ntx; i++) tick();
      check("tx_count", tx_done_cnt - txd0, ntx);

      k = 0;
      if (kind != 1) begin
         repeat ($urandom_range(2, 40)) tick();
         send_word(sw, (kind == 3) ? 1'b0 : 1'b1);
         if (t && kind != 2 && kind != 3) begin
            k = (kind == 0) ? n : k_in;
            for (int unsigned i = 0; i < k; i++) begin
               rxd[i] = seq_data ? 16'(i) : 16'($urandom);
               repeat ($urandom_range(2, 60)) tick();
               send_word(rxd[i], 1'b0);
            end
            if (kind == 5) begin
               repeat (5) tick();
               send_word(16'($urandom), 1'b1);
            end
         end
      end

      case (kind)
         0: exp_err = 2'd0;
         1: exp_err = 2'd1;
         2: exp_err = 2'd2;
         4: exp_err = 2'd1;
         default: exp_err = 2'd3;
      endcase
      if (kind != 1 && kind != 3) exp_stat = sw;

      for (int i = 0; i < RESP_TO + WORD_TO + 100 && done_cnt == done0; i++) tick();
      repeat (3) tick();
      check("done_pulses", done_cnt - done0, 1);
      check("err", 32'(err_at_done), 32'(exp_err));
      check("busy_at_done", 32'(busy_at_done), 0);
      check("err_held", 32'(err), 32'(exp_err));
      check("stat_wd", 32'(stat_wd), 32'(exp_stat));
      if (kind == 1 && fall_q.size() > 0)
         check("resp_timeout_lat", done_cyc - fall_q[$], RESP_TO + 2);
      else if (kind == 4)
         check("word_timeout_lat", done_cyc - last_ok_cyc, WORD_TO + 2);
      else if (kind != 1)
         check("done_lat", done_cyc - last_ok_cyc, 1);

      check("tx_words", tx_q.size(), ntx);
      for (int unsigned i = 0; i < ntx && i < tx_q.size(); i++) begin
         if (i == 0) e = {1'b1, cw};
         else e = {1'b0, mem[i-1]};
         check("tx_word", 32'(tx_q[i]), 32'(e));
         if (i > 0 && fall_q.size() >= i) check("dw_latency", tx_cyc_q[i] - fall_q[i-1], 3);
      end

      nwr = (t && (kind == 0 || kind == 4 || kind == 5)) ? k : 0;
      check("wr_count", wr_q.size(), nwr);
      for (int unsigned i = 0; i < nwr && i < wr_q.size(); i++)
         check("wr_entry", 32'(wr_q[i]), 32'({5'(i), rxd[i]}));
   endtask

   initial begin
      int unsigned txd0, done0, n, kind, k;
      logic [4:0]  a, s, w;
      logic        t;
      logic [15:0] sw;

      rst = 1'b1; start = 1'b0; ok_rx = 1'b0; cw_dw = 1'b0; sr_dat = '0;
      rt_addr = '0; tr = 1'b0; sub_addr = '0; wcnt = '0;
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      repeat (3) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_stat", 32'(stat_wd), 0);
      check("rst_txen", 32'(txen), 0);
      check("rst_dat", 32'(dat), 0);
      check("rst_txcw", 32'(tx_cw), 0);
      check("rst_bufra", 32'(buf_ra), 0);
      check("rst_bufwe", 32'(buf_we), 0);
      check("rst_bufwa", 32'(buf_wa), 0);
      check("rst_bufwd", 32'(buf_wd), 0);
      rst = 1'b0;
      tick();

      mem[0] = 16'h1234;
      mem[1] = 16'hABCD;
      run_msg(5'd5, 1'b0, 5'd3, 5'd2, 0, 16'h2800, 1'b0, 0);
      check("plan_cw", 32'(tx_q[0]), 32'h12862);
      run_msg(5'd5, 1'b1, 5'd7, 5'd0, 0, 16'h2800, 1'b1, 0);
      run_msg(5'd9, 1'b0, 5'd1, 5'd1, 1, 16'h0000, 1'b0, 0);
      run_msg(5'd5, 1'b1, 5'd2, 5'd4, 2, 16'h3000, 1'b0, 0);
      run_msg(5'd5, 1'b1, 5'd2, 5'd3, 3, 16'h2800, 1'b0, 0);

      // reset while the first data word is on the wire
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      txd0 = tx_done_cnt;
      done0 = done_cnt;
      rt_addr = 5'd7; tr = 1'b0; sub_addr = 5'd1; wcnt = 5'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 200 && tx_done_cnt < txd0 + 1; i++) tick();
      for (int i = 0; i < 200 && !tx_busy; i++) tick();
      check("dw_in_flight", 32'(tx_busy), 1);
      rst = 1'b1;
      tick();
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_txen", 32'(txen), 0);
      check("mid_rst_dat", 32'(dat), 0);
      check("mid_rst_stat", 32'(stat_wd), 0);
      rst = 1'b0;
      exp_stat = '0;
      for (int i = 0; i < 200 && tx_busy; i++) tick();
      repeat (10) tick();
      check("mid_rst_no_done", done_cnt - done0, 0);
      check("mid_rst_idle", 32'(busy), 0);
      run_msg(5'd7, 1'b0, 5'd1, 5'd3, 0, 16'h3812, 1'b0, 0);

      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
         a = 5'($urandom);
         t = 1'($urandom);
         s = 5'($urandom);
         case ($urandom_range(0, 3))
            0: w = 5'd0;
            1: w = 5'd1;
            default: w = 5'($urandom);
         endcase
         n = (w == 5'd0) ? 32 : int'(w);
         kind = $urandom_range(0, 5);
         if (!t && kind > 3) kind = 0;
         k = $urandom_range(0, n - 1);
         if (kind == 2) sw = {a ^ 5'($urandom_range(1, 31)), 11'($urandom)};
         else sw = {a, 11'($urandom)};
         run_msg(a, t, s, w, int'(kind), sw, 1'b0, k);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mil_bc_seq.md
# mil_bc_seq

Bus-controller message sequencer for the MIL-STD-1553 link. It takes one host message request and sequences the transmitter: command word, then data words. It then monitors the receiver for the remote terminal's status word and data words. It sits between the host/data buffer and the MIL_TXD / MIL_RXD pair, and supports BC→RT (receive command) and RT→BC (transmit command) transfers.

## Interface
Parameters:
- RESP_TO, 2000: clocks allowed from end of last transmitted word (tx_busy fall) to ok_rx of the status word (≈40 µs at 50 MHz; covers response gap plus word time).
- WORD_TO, 1100: clocks allowed between consecutive ok_rx pulses while receiving RT data words.

Ports:
- clk  in  1  system clock (50 MHz, shared with MIL_TXD/MIL_RXD).
- rst  in  1  synchronous reset, active high.
- start  in  1  one-cycle request; sampled only in IDLE.
- rt_addr  in  5  RT address; sampled with start.
- tr  in  1  0 = BC→RT, 1 = RT→BC; sampled with start.
- sub_addr  in  5  subaddress; sampled with start.
- wcnt  in  5  word count; 0 means 32; sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at message end.
- err  out  2  valid with done, held until next start: 0 ok, 1 timeout, 2 status address mismatch, 3 sync-type error.
- stat_wd  out  16  last received status word, held.
- buf_ra  out  5  data buffer read address (BC→RT source).
- buf_rd  in  16  buffer read data, valid one clock after buf_ra.
- buf_we  out  1  buffer write strobe (RT→BC sink).
- buf_wa  out  5  buffer write address.
- buf_wd  out  16  buffer write data.
- txen  out  1  one-cycle transmit request to MIL_TXD.
- dat  out  16  word to transmit; stable from txen until next txen.
- tx_cw  out  1  sync type for the word: 1 = command/status sync, 0 = data sync.
- tx_busy  in  1  transmitter busy.
- ok_rx  in  1  one-cycle received-word-valid strobe from MIL_RXD.
- sr_dat  in  16  received word, valid with ok_rx.
- CW_DW  in  1  received sync type, valid with ok_rx: 1 = command/status, 0 = data.

## Operation
- Command word: {rt_addr, tr, sub_addr, wcnt}. Internal count N = (wcnt==0) ? 32 : wcnt; index counter is 6 bits.
- States:
  - IDLE
  - CW_TX
  - CW_WAIT
  - DW_FETCH
  - DW_TX
  - DW_WAIT
  - SW_WAIT
  - RX_DW
  - FIN
- IDLE, start=1: latch request, assert busy, go to CW_TX.
- CW_TX: dat=CW, tx_cw=1, txen=1 for one cycle, then CW_WAIT.
- CW_WAIT / DW_WAIT: wait for tx_busy rise, then fall. On fall:
  - BC→RT with idx<N: DW_FETCH.
  - Otherwise: SW_WAIT, with the timer loaded to RESP_TO.
- DW_FETCH: buf_ra=idx, then DW_TX.
- DW_TX: dat=buf_rd, tx_cw=0, txen=1, idx+1, then DW_WAIT.
- SW_WAIT, ok_rx:
  - If CW_DW=0: err=3, FIN.
  - Else latch stat_wd=sr_dat.
  - If sr_dat[15:11]≠rt_addr: err=2, FIN.
  - Else if tr=1: go to RX_DW, timer=WORD_TO.
  - Else: FIN with err=0.
- SW_WAIT, timer reaches 0 without ok_rx: err=1, FIN.
- RX_DW, ok_rx with CW_DW=0: buf_we=1, buf_wa=idx, buf_wd=sr_dat, idx+1, timer reloads. After the N-th word: FIN, err=0.
- RX_DW, ok_rx with CW_DW=1: err=3, FIN.
- RX_DW timeout: err=1, FIN. Words already written stay written.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Simultaneous ok_rx and timer expiry in the same cycle: ok_rx wins.
- start while busy: ignored.
- ok_rx outside SW_WAIT/RX_DW: ignored.

## Timing
- Reset values:
  - busy=0, done=0, err=0, stat_wd=0.
  - txen=0, dat=0, tx_cw=0.
  - buf_ra=0, buf_we=0, buf_wa=0, buf_wd=0.
  - State IDLE.
- rst high in any state: IDLE on the next edge, all outputs at reset values, no done pulse.
- start sampled at edge k → busy=1 and txen=1 with CW at edge k+1.
- tx_busy fall sampled at edge f → buf_ra valid f+1 → txen for the data word at f+2.
- Timer decrements once per clock from the load value. Expiry is the cycle the timer is 0.
- buf_we is asserted in the cycle after ok_rx is sampled.
- done is asserted 1 cycle after the terminating event; busy falls in the same cycle.

## Test plan
- BC→RT, rt_addr=5, sub_addr=3, wcnt=2, buffer {0x1234, 0xABCD}; TX/RX loopback answers status 0x2800 → txen with CW 0x2862 (tx_cw=1), then 0x1234 and 0xABCD (tx_cw=0); done with err=0, stat_wd=0x2800.
- RT→BC, rt_addr=5, wcnt=0: status 0x2800, then 32 data words 0x0000..0x001F → 32 buf_we pulses with buf_wa=0..31 and matching data; err=0.
- No response after CW: done exactly RESP_TO+1 cycles after tx_busy fall, err=1.
- Status word 0x3000 (address 6) for rt_addr=5 → err=2, stat_wd=0x3000, no buffer writes.
- RT→BC, ok_rx with CW_DW=0 where a status is expected → err=3. Separately, rst pulsed during DW_WAIT → busy=0 next cycle, no done; a following start runs normally.
